// File: rtl/cpu_hpm.sv
// rtl/cpu_hpm.sv - machine/user performance counters, event selectors, inhibit and overflow irq
module cpu_hpm #(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  retired_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [11:0]           csr_read_addr_i,
    input  logic                  csr_read_enable_i,
    output logic [31:0]           csr_read_data_o,
    output logic                  csr_read_hit_o,
    input  logic [11:0]           csr_write_addr_i,
    input  logic [31:0]           csr_write_data_i,
    input  logic                  csr_write_enable_i,
    output logic                  overflow_irq_o
);

    localparam int W    = COUNTER_WIDTH;
    localparam int NC_A = (NUM_COUNTERS > 0) ? NUM_COUNTERS : 1;

    // Writable mcountinhibit bits: mcycle, minstret and the populated hpm counters.
    function automatic logic [31:0] f_inh_mask(input int n);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i == 0) || (i == 2) || ((i >= 3) && (i < 3 + n));
        end
        return m;
    endfunction

    localparam logic [31:0] INH_MASK = f_inh_mask(NUM_COUNTERS);

    // Replace one 32-bit half of a counter, keeping the other half.
    function automatic logic [W-1:0] f_wr(input logic [W-1:0] cnt, input logic hi, input logic [31:0] d);
        logic [W-1:0] v;
        v = cnt;
        if (hi) begin
            v[W-1:32] = d[W-33:0];
        end else begin
            v[31:0] = d;
        end
        return v;
    endfunction

    logic              r_armed;
    logic [W-1:0]      r_mcycle;
    logic [W-1:0]      r_minstret;
    logic [W-1:0]      r_hpm [NC_A];
    logic [7:0]        r_sel [NC_A];
    logic [NC_A-1:0]   r_of;
    logic [31:0]       r_inh;
    logic [31:0]       r_rd_data;
    logic              r_rd_hit;
    logic              r_irq;

    logic              w_wr_lo;
    logic              w_wr_hi;
    logic              w_wr_cnt;
    logic              w_wr_inh;
    logic              w_wr_evt;
    logic [4:0]        w_wr_idx;
    logic [255:0]      w_ev_ext;
    logic [NC_A-1:0]   w_hpm_inc;
    logic [4:0]        w_rd_idx;
    logic [63:0]       w_cnt64;
    logic              w_cnt_hit;
    logic [31:0]       w_rd_data;
    logic              w_rd_hit;

    // Write decode and per-counter event selection.
    always_comb begin
        w_wr_idx  = csr_write_addr_i[4:0];
        w_wr_lo   = csr_write_enable_i && (csr_write_addr_i[11:5] == 7'h58);
        w_wr_hi   = csr_write_enable_i && (csr_write_addr_i[11:5] == 7'h5C);
        w_wr_cnt  = w_wr_lo || w_wr_hi;
        w_wr_inh  = csr_write_enable_i && (csr_write_addr_i == 12'h320);
        w_wr_evt  = csr_write_enable_i && (csr_write_addr_i[11:5] == 7'h19) && (w_wr_idx >= 5'd3);
        w_ev_ext  = 256'(event_i);
        w_hpm_inc = '0;
        for (int j = 0; j < NUM_COUNTERS; j++) begin
            w_hpm_inc[j] = r_armed && !r_inh[j+3] && (r_sel[j] != 8'd0) && w_ev_ext[r_sel[j] - 8'd1];
        end
    end

    // Counter, selector, inhibit and overflow state; a CSR write to a counter suppresses its increment.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_armed    <= 1'b0;
            r_mcycle   <= '0;
            r_minstret <= '0;
            r_inh      <= '0;
            r_of       <= '0;
            r_irq      <= 1'b0;
            for (int j = 0; j < NC_A; j++) begin
                r_hpm[j] <= '0;
                r_sel[j] <= '0;
            end
        end else begin
            r_armed <= 1'b1;
            r_irq   <= |r_of;

            if (w_wr_cnt && (w_wr_idx == 5'd0)) begin
                r_mcycle <= f_wr(r_mcycle, w_wr_hi, csr_write_data_i);
            end else if (r_armed && !r_inh[0]) begin
                r_mcycle <= r_mcycle + W'(1);
            end

            if (w_wr_cnt && (w_wr_idx == 5'd2)) begin
                r_minstret <= f_wr(r_minstret, w_wr_hi, csr_write_data_i);
            end else if (r_armed && !r_inh[2] && retired_i) begin
                r_minstret <= r_minstret + W'(1);
            end

            if (w_wr_inh) begin
                r_inh <= csr_write_data_i & INH_MASK;
            end

            for (int j = 0; j < NUM_COUNTERS; j++) begin
                if (w_wr_evt && (w_wr_idx == 5'(j + 3))) begin
                    r_sel[j] <= csr_write_data_i[7:0];
                    r_of[j]  <= csr_write_data_i[31];
                end
                if (w_wr_cnt && (w_wr_idx == 5'(j + 3))) begin
                    r_hpm[j] <= f_wr(r_hpm[j], w_wr_hi, csr_write_data_i);
                end else if (w_hpm_inc[j]) begin
                    r_hpm[j] <= r_hpm[j] + W'(1);
                    if (&r_hpm[j]) begin
                        r_of[j] <= 1'b1;
                    end
                end
            end
        end
    end

    // Read address decode and data selection.
    always_comb begin
        w_rd_idx  = csr_read_addr_i[4:0];
        w_cnt64   = '0;
        w_cnt_hit = 1'b0;
        w_rd_data = '0;
        w_rd_hit  = 1'b0;
        if (w_rd_idx == 5'd0) begin
            w_cnt64   = 64'(r_mcycle);
            w_cnt_hit = 1'b1;
        end else if (w_rd_idx == 5'd2) begin
            w_cnt64   = 64'(r_minstret);
            w_cnt_hit = 1'b1;
        end else if (w_rd_idx >= 5'd3) begin
            w_cnt_hit = 1'b1;
            for (int j = 0; j < NUM_COUNTERS; j++) begin
                if (w_rd_idx == 5'(j + 3)) begin
                    w_cnt64 = 64'(r_hpm[j]);
                end
            end
        end
        if (csr_read_enable_i) begin
            case (csr_read_addr_i[11:5])
                7'h58, 7'h60: begin
                    w_rd_hit  = w_cnt_hit;
                    w_rd_data = w_cnt64[31:0];
                end
                7'h5C, 7'h64: begin
                    w_rd_hit  = w_cnt_hit;
                    w_rd_data = w_cnt64[63:32];
                end
                7'h19: begin
                    if (w_rd_idx == 5'd0) begin
                        w_rd_hit  = 1'b1;
                        w_rd_data = r_inh;
                    end else if (w_rd_idx >= 5'd3) begin
                        w_rd_hit = 1'b1;
                        for (int j = 0; j < NUM_COUNTERS; j++) begin
                            if (w_rd_idx == 5'(j + 3)) begin
                                w_rd_data = {r_of[j], 23'd0, r_sel[j]};
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // One-cycle registered read response.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_data <= '0;
            r_rd_hit  <= 1'b0;
        end else begin
            r_rd_data <= w_rd_data;
            r_rd_hit  <= w_rd_hit;
        end
    end

    assign csr_read_data_o = r_rd_data;
    assign csr_read_hit_o  = r_rd_hit;
    assign overflow_irq_o  = r_irq;

endmodule
